// File: rtl/mod997_pkg.sv
// Shared constants and types for the mod-997 serial multiplier datapath.
package mod997_pkg;

   localparam int unsigned MOD   = 997;
   localparam int unsigned RES_W = 10;
   localparam int unsigned DIG_W = 3;
   localparam int unsigned N_DIG = 4;
   localparam int unsigned SUM_W = 14;
   localparam int unsigned OPB_W = DIG_W * N_DIG;
   localparam int unsigned K_W   = 2;

   localparam logic [RES_W-1:0] MOD_R = 10'd997;
   localparam logic [SUM_W-1:0] MOD_S = 14'd997;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [DIG_W-1:0] digit_at(input logic [OPB_W-1:0] b,
                                                 input logic [K_W-1:0]   k);
      return b[k*DIG_W +: DIG_W];
   endfunction

   function automatic logic is_illegal(input logic [RES_W-1:0] v);
      return v >= MOD_R;
   endfunction

endpackage

// File: rtl/mod997_serial_mult_if.sv
// Operand/result handshake bundle for the mod-997 serial multiplier.
interface mod997_serial_mult_if;
   import mod997_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [RES_W-1:0] a;
   logic [RES_W-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] z;
   logic             err;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, z, err
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, z, err
   );

endinterface

// File: rtl/mod997_reduce.sv
// Combinational s mod 997 for s < 14957 (one Horner step's worst-case sum).
module mod997_reduce
   import mod997_pkg::*;
(
   input  logic [SUM_W-1:0] s_i,
   output logic [RES_W-1:0] r_o
);

   logic [SUM_W-RES_W-1:0] q;
   logic [SUM_W-1:0]       qm;
   logic [SUM_W-1:0]       r1;
   logic [SUM_W-1:0]       r2;

   // s/1024 trails s/997 by under 0.4 over this range, so the quotient is short by at most one.
   assign q  = s_i[SUM_W-1:RES_W];
   assign qm = SUM_W'(q) * MOD_S;
   assign r1 = s_i - qm;
   assign r2 = (r1 >= MOD_S) ? (r1 - MOD_S) : r1;
   assign r_o = RES_W'(r2);

endmodule

// File: rtl/mod997_serial_mult.sv
// a*b mod 997 via Horner over 3-bit digits of b, MSB first, one digit per cycle.
module mod997_serial_mult
   import mod997_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   mod997_serial_mult_if.slave bus
);

   state_t           state_q, state_d;
   logic [RES_W-1:0] a_q, a_d;
   logic [OPB_W-1:0] b_q, b_d;
   logic [RES_W-1:0] acc_q, acc_d;
   logic [K_W-1:0]   k_q, k_d;
   logic             err_q, err_d;
   logic [RES_W-1:0] z_q, z_d;

   logic [DIG_W-1:0] dig;
   logic [SUM_W-1:0] sum;
   logic [RES_W-1:0] red;

   assign dig = digit_at(b_q, k_q);
   assign sum = SUM_W'({acc_q, 3'b000}) + SUM_W'(dig) * SUM_W'(a_q);

   mod997_reduce u_reduce (
      .s_i (sum),
      .r_o (red)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         err_q   <= err_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      k_d     = k_q;
      err_d   = err_q;
      z_d     = z_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = RUN;
               a_d     = bus.a;
               b_d     = OPB_W'(bus.b);
               acc_d   = '0;
               k_d     = K_W'(N_DIG - 1);
               err_d   = is_illegal(bus.a) | is_illegal(bus.b);
               z_d     = '0;
            end
         end
         RUN: begin
            acc_d = red;
            k_d   = k_q - K_W'(1);
            // Illegal operands still run the full sequence; only the result is masked.
            if (k_q == '0) begin
               state_d = DONE;
               z_d     = err_q ? '0 : red;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.z         = z_q;
   assign bus.err       = err_q & (state_q == DONE);

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.z) && $stable(bus.err));

   a_acc_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      acc_q < MOD_R);

endmodule

// File: tb/tb_mod997_serial_mult.sv
// Directed-table and randomized bench for mod997_serial_mult, plus an exhaustive sweep of mod997_reduce.
module tb_mod997_serial_mult;
   import mod997_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mod997_serial_mult_if bus();

   mod997_serial_mult dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [SUM_W-1:0] red_s;
   logic [RES_W-1:0] red_r;

   mod997_reduce u_red (
      .s_i (red_s),
      .r_o (red_r)
   );

   typedef struct {
      logic [9:0] a;
      logic [9:0] b;
      int         z;
      int         err;
   } vec_t;

   vec_t tbl[8];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic do_op(input string nm, input logic [9:0] a, input logic [9:0] b,
                        input int ez, input int eerr);
      int lat;
      check({nm, "_in_ready"}, int'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = 10'h3ff;
      bus.b        = 10'h155;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, lat, 4);
      check({nm, "_z"}, int'(bus.z), ez);
      check({nm, "_err"}, int'(bus.err), eerr);
      check({nm, "_busy"}, int'(bus.in_ready), 0);
      @(posedge clk); @(negedge clk);
      check({nm, "_ret_idle"}, int'({bus.out_valid, bus.in_ready}), 1);
   endtask

   initial begin
      int  lat;
      int  guard;
      int  exp_z;
      bit  seen;
      bit  abort;
      logic [9:0] ra, rb;

      tbl[0] = '{a: 10'd123, b: 10'd456,  z: 256, err: 0};
      tbl[1] = '{a: 10'd996, b: 10'd996,  z: 1,   err: 0};
      tbl[2] = '{a: 10'd2,   b: 10'd500,  z: 3,   err: 0};
      tbl[3] = '{a: 10'd0,   b: 10'd777,  z: 0,   err: 0};
      tbl[4] = '{a: 10'd997, b: 10'd5,    z: 0,   err: 1};
      tbl[5] = '{a: 10'd5,   b: 10'd7,    z: 35,  err: 0};
      tbl[6] = '{a: 10'd10,  b: 10'd1000, z: 0,   err: 1};
      tbl[7] = '{a: 10'd1,   b: 10'd996,  z: 996, err: 0};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      red_s         = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_z",         int'(bus.z), 0);
      check("rst_err",       int'(bus.err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].z, tbl[i].err);

      // Result held under backpressure; in_valid pulses must be ignored.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.a         = 10'd3;
      bus.b         = 10'd4;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check("stall_latency", lat, 4);
      for (int c = 0; c < 10; c++) begin
         check("stall_out_valid", int'(bus.out_valid), 1);
         check("stall_z", int'(bus.z), 12);
         check("stall_in_ready", int'(bus.in_ready), 0);
         bus.in_valid = c[0];
         bus.a        = 10'd50;
         bus.b        = 10'd60;
         @(posedge clk); @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("stall_release", int'({bus.out_valid, bus.in_ready}), 1);
      do_op("after_stall", 10'd5, 10'd7, 35, 0);

      // Reset asserted between the first and second digit steps.
      bus.in_valid = 1'b1;
      bus.a        = 10'd996;
      bus.b        = 10'd996;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready",  int'(bus.in_ready), 1);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); @(negedge clk);
         seen |= bus.out_valid;
      end
      check("midrst_no_result", int'(seen), 0);
      check("midrst_idle", int'(bus.in_ready), 1);
      do_op("after_rst", 10'd10, 10'd100, 3, 0);

      // Randomized traffic with downstream stalls.
      abort = 1'b0;
      for (int i = 0; i < 10000 && !abort; i++) begin
         ra = 10'($urandom_range(0, 996));
         rb = 10'($urandom_range(0, 996));
         exp_z = (int'(ra) * int'(rb)) % 997;
         bus.in_valid = 1'b1;
         bus.a        = ra;
         bus.b        = rb;
         @(posedge clk); @(negedge clk);
         bus.in_valid = 1'b0;
         guard = 0;
         forever begin
            bus.out_ready = ($urandom_range(0, 7) != 0);
            if ((bus.out_valid && bus.out_ready) || guard >= 60) break;
            @(posedge clk); @(negedge clk);
            guard++;
         end
         if (guard >= 60) begin
            check("rand_timeout", guard, 0);
            abort = 1'b1;
         end else begin
            check("rand_z", int'(bus.z), exp_z);
            @(posedge clk); @(negedge clk);
            check("rand_no_dup", int'({bus.out_valid, bus.in_ready}), 1);
         end
      end

      for (int i = 0; i < 14957; i++) begin
         red_s = SUM_W'(i);
         #1;
         check("reduce", int'(red_r), i % 997);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
